// File: rtl/stack2_pipe4_pkg.sv
// ============================================================================
// Module      : stack2_pipe4_pkg
// Description : Shared stack-move encodings and Gray context-pointer codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack2_pipe4_pkg;

    localparam int         c_NUM_CTX = 4;

    // delta is {pop, move}; 2'b10 is reserved and behaves as freeze
    localparam logic [1:0] c_FREEZE  = 2'b00;
    localparam logic [1:0] c_PUSH    = 2'b01;
    localparam logic [1:0] c_POP     = 2'b11;

    localparam logic [1:0] c_GRAY0   = 2'b00;
    localparam logic [1:0] c_GRAY1   = 2'b01;
    localparam logic [1:0] c_GRAY2   = 2'b11;
    localparam logic [1:0] c_GRAY3   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/stack2_pipe4_greycount.sv
// ============================================================================
// Module      : greycount
// Description : Combinational successor of a 2-bit Gray code (00-01-11-10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module greycount
    import stack2_pipe4_pkg::*;
(
    input  logic [1:0] last,
    output logic [1:0] next
);

    always_comb begin
        next = c_GRAY0;
        case (last)
            c_GRAY0: next = c_GRAY1;
            c_GRAY1: next = c_GRAY2;
            c_GRAY2: next = c_GRAY3;
            c_GRAY3: next = c_GRAY0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/stack2_pipe4.sv
// ============================================================================
// Module      : stack2_pipe4
// Description : Four interleaved register stacks, one serviced per clock in
//               Gray-code rotation; rd shows the head of the active context.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack2_pipe4
    import stack2_pipe4_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] rd,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic [1:0]       delta
);

    logic [1:0]                        r_ptr;
    logic [1:0]                        w_ptr_next;
    logic [c_NUM_CTX-1:0][WIDTH-1:0]   w_heads;

    greycount u_greycount (
        .last (r_ptr),
        .next (w_ptr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= c_GRAY0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    // Contexts are identified by the raw pointer value, not by rotation order
    generate
        for (genvar c = 0; c < c_NUM_CTX; c++) begin : g_ctx
            logic [WIDTH-1:0] r_head;
            logic [WIDTH-1:0] r_tail [DEPTH];
            logic             w_sel;

            assign w_sel      = (r_ptr == 2'(c));
            assign w_heads[c] = r_head;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_head <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_tail[i] <= '0;
                    end
                end else if (w_sel) begin
                    case (delta)
                        c_PUSH: begin
                            r_tail[0] <= r_head;
                            for (int i = 1; i < DEPTH; i++) begin
                                r_tail[i] <= r_tail[i-1];
                            end
                            r_head <= we ? wd : r_head;
                        end
                        c_POP: begin
                            r_head <= we ? wd : r_tail[0];
                            for (int i = 0; i < DEPTH - 1; i++) begin
                                r_tail[i] <= r_tail[i+1];
                            end
                            r_tail[DEPTH-1] <= '0;
                        end
                        default: begin
                            r_head <= we ? wd : r_head;
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign rd = w_heads[r_ptr];

endmodule

`default_nettype wire

// File: tb/tb_stack2_pipe4.sv
// ============================================================================
// Module      : tb_stack2_pipe4
// Description : Directed vector table plus multi-cycle sequences for stack2_pipe4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack2_pipe4;
    import stack2_pipe4_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] JUNK = 16'hDEAD;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] rd;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic [1:0]       delta;

    logic [1:0]       gc_last;
    logic [1:0]       gc_next;

    int checks   = 0;
    int failures = 0;
    logic [1:0] ptr_m;

    typedef struct {
        logic             rst;
        logic             we;
        logic [WIDTH-1:0] wd;
        logic [1:0]       delta;
        logic [WIDTH-1:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    stack2_pipe4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .we    (we),
        .wd    (wd),
        .delta (delta)
    );

    greycount u_gc (
        .last (gc_last),
        .next (gc_next)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] gray_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [WIDTH-1:0] d,
                       input logic [1:0] dl, input logic [WIDTH-1:0] e);
        vec_t v;
        v.rst = r; v.we = w; v.wd = d; v.delta = dl; v.exp_rd = e;
        vecs.push_back(v);
    endtask

    // One clock with the given inputs; pointer model advances alongside
    task automatic cyc(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic [1:0] dl);
        reset = r; we = w; wd = d; delta = dl;
        @(posedge clk);
        #1;
        ptr_m = r ? 2'b00 : gray_next(ptr_m);
        reset = 1'b0; we = 1'b0; wd = JUNK; delta = c_FREEZE;
    endtask

    // Operation on context 00 (pointer must be 00), then idle back to it and check head
    task automatic op0(input logic w, input logic [WIDTH-1:0] d, input logic [1:0] dl,
                       input logic [WIDTH-1:0] exp, input string name);
        cyc(1'b0, w, d, dl);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, JUNK, c_FREEZE);
        check({name, "_ptr"}, {14'd0, dut.r_ptr}, {14'd0, ptr_m});
        check(name, rd, exp);
    endtask

    initial begin
        logic [1:0] gc_exp [4];
        reset = 1'b0; we = 1'b0; wd = JUNK; delta = c_FREEZE; ptr_m = 2'b00;

        // Combinational Gray successor over every input
        gc_exp[0] = 2'b01; gc_exp[1] = 2'b11; gc_exp[2] = 2'b00; gc_exp[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            gc_last = 2'(i);
            #1;
            check($sformatf("greycount_%0d", i), {14'd0, gc_next}, {14'd0, gc_exp[i]});
        end

        // Vector table: reset, idle pointer walk, then push/pop on context 00
        add(1, 1, 16'h0055, c_PUSH, 0);
        for (int i = 0; i < 4; i++) add(0, 0, JUNK, c_FREEZE, 0);
        for (int v = 1; v <= 3; v++) begin
            add(0, 1, 16'(v), c_PUSH, 0);
            add(0, 0, JUNK, c_FREEZE, 0);
            add(0, 0, JUNK, c_FREEZE, 0);
            add(0, 0, JUNK, c_FREEZE, 16'(v));
        end
        for (int v = 2; v >= 0; v--) begin
            add(0, 0, JUNK, c_POP, 0);
            add(0, 0, JUNK, c_FREEZE, 0);
            add(0, 0, JUNK, c_FREEZE, 0);
            add(0, 0, JUNK, c_FREEZE, 16'(v));
        end

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].delta);
            check($sformatf("vec%0d_ptr", i), {14'd0, dut.r_ptr}, {14'd0, ptr_m});
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Overflow: six pushes into a 4-deep tail, then drain
        cyc(1'b1, 1'b0, JUNK, c_FREEZE);
        for (int v = 1; v <= 6; v++) op0(1'b1, 16'(v), c_PUSH, 16'(v), $sformatf("ovf_push%0d", v));
        op0(1'b1, 16'h0077, 2'b10, 16'h0077, "reserved_as_freeze_write");
        op0(1'b0, JUNK, 2'b10, 16'h0077, "reserved_as_freeze_hold");
        op0(1'b0, JUNK, c_POP, 16'd5, "ovf_pop1");
        op0(1'b0, JUNK, c_POP, 16'd4, "ovf_pop2");
        op0(1'b0, JUNK, c_POP, 16'd3, "ovf_pop3");
        op0(1'b0, JUNK, c_POP, 16'd2, "ovf_pop4");
        op0(1'b0, JUNK, c_POP, 16'd0, "ovf_pop5");
        op0(1'b0, JUNK, c_POP, 16'd0, "ovf_pop6");

        // Push without write duplicates the head
        op0(1'b1, 16'd8, c_FREEZE, 16'd8, "dup_setup");
        op0(1'b0, JUNK, c_PUSH, 16'd8, "dup_push");
        op0(1'b0, JUNK, c_POP, 16'd8, "dup_pop");
        op0(1'b0, JUNK, c_POP, 16'd0, "dup_pop_empty");

        // Write-with-pop and write-with-freeze
        cyc(1'b1, 1'b0, JUNK, c_FREEZE);
        op0(1'b1, 16'd1, c_PUSH, 16'd1, "wp_push1");
        op0(1'b1, 16'd2, c_PUSH, 16'd2, "wp_push2");
        op0(1'b1, 16'd3, c_PUSH, 16'd3, "wp_push3");
        op0(1'b1, 16'd9, c_POP, 16'd9, "wp_writepop");
        op0(1'b1, 16'd7, c_FREEZE, 16'd7, "wp_writefreeze");
        op0(1'b0, JUNK, c_POP, 16'd1, "wp_tail0");
        op0(1'b0, JUNK, c_POP, 16'd0, "wp_tail1");

        // Mid-operation reset with data in every context
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'(16'h10 + k), c_PUSH);
        cyc(1'b0, 1'b0, JUNK, c_FREEZE);
        check("mid_pre_ctx01", rd, 16'h0011);
        cyc(1'b1, 1'b1, 16'h0055, c_PUSH);
        check("mid_reset_ptr", {14'd0, dut.r_ptr}, 16'd0);
        check("mid_reset_rd", rd, 16'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, JUNK, c_FREEZE);
            check($sformatf("mid_after%0d_ptr", k), {14'd0, dut.r_ptr}, {14'd0, ptr_m});
            check($sformatf("mid_after%0d_rd", k), rd, 16'd0);
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, JUNK, c_POP);
        check("mid_tail_cleared", rd, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
